// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for a fixed
// latency, then commits the store or returns the loaded word in a one-cycle DONE.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_is_write;
  logic          r_reject;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_reject_in;
  logic          w_accept;
  logic          w_finish;
  logic          w_commit;

  assign w_req       = MemRead | MemWrite;
  assign w_reject_in = (Address[1:0] != 2'b00) | (MemRead & MemWrite);
  assign w_accept    = (r_state == S_IDLE) && w_req;
  assign w_finish    = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_commit    = w_finish && r_is_write && !r_reject;

  // Address bits above the word index are ignored, so addresses alias.
  if (AW + 2 < 32) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^Address[31:AW+2];
  end

  always_comb begin
    w_state_next = r_state;
    MemStall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        MemStall = w_req;
        if (w_req) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        MemStall = 1'b1;
        if (r_cnt == 4'd0) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_reject   <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_idx      <= Address[AW+1:2];
        r_wdata    <= WriteData;
        r_is_write <= MemWrite;
        r_reject   <= w_reject_in;
        r_cnt      <= 4'(LATENCY - 1);
      end
      if ((r_state == S_BUSY) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
      if (w_finish) begin
        if (r_reject) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end else if (!r_is_write) begin
          r_rdata <= r_mem[r_idx];
        end
      end
    end
  end

  // Store array has no reset; gating on rst keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) r_mem[r_idx] <= r_wdata;
  end

  assign ReadData = r_rdata;
  assign Err      = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: per-cycle stall/DONE checks on
// reads, writes, rejects, mid-access reset and address aliasing.
module tb_data_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemStall;
  logic        Err;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .MemStall (MemStall),
    .Err      (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full request: acceptance, LAT busy cycles (inputs scrambled), DONE, then IDLE.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wdata;
    #1;
    chk($sformatf("%s accept_stall", tag), {31'd0, MemStall}, 32'd1);
    for (int i = 0; i < LAT; i++) begin
      step();
      chk($sformatf("%s busy%0d_stall", tag, i), {31'd0, MemStall}, 32'd1);
      Address   = ~addr;
      WriteData = ~wdata;
    end
    Address   = addr;
    WriteData = wdata;
    step();
    chk($sformatf("%s done_stall", tag), {31'd0, MemStall}, 32'd0);
    chk($sformatf("%s done_err", tag), {31'd0, Err}, {31'd0, exp_err});
    chk($sformatf("%s done_rdata", tag), ReadData, exp_rd);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    step();
    chk($sformatf("%s idle_stall", tag), {31'd0, MemStall}, 32'd0);
    chk($sformatf("%s idle_err", tag), {31'd0, Err}, 32'd0);
    chk($sformatf("%s idle_rdata_hold", tag), ReadData, exp_rd);
  endtask

  initial begin
    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    step();
    step();
    chk("reset stall", {31'd0, MemStall}, 32'd0);
    chk("reset err", {31'd0, Err}, 32'd0);
    chk("reset rdata", ReadData, 32'd0);
    rst = 1'b0;
    step();

    // 1: write then read back
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "t1_wr");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t1_rd");

    // 2: MemRead held across two requests; DONE must not accept
    do_req(1'b0, 1'b1, 32'h20, 32'h20202020, 32'hDEADBEEF, 1'b0, "t2_wr20");
    do_req(1'b0, 1'b1, 32'h24, 32'h24242424, 32'hDEADBEEF, 1'b0, "t2_wr24");
    MemRead = 1'b1;
    Address = 32'h20;
    #1;
    chk("t2 a_accept_stall", {31'd0, MemStall}, 32'd1);
    for (int i = 0; i < LAT; i++) begin
      step();
      chk($sformatf("t2 a_busy%0d_stall", i), {31'd0, MemStall}, 32'd1);
    end
    step();
    chk("t2 a_done_stall", {31'd0, MemStall}, 32'd0);
    chk("t2 a_done_rdata", ReadData, 32'h20202020);
    Address = 32'h24;
    step();
    chk("t2 b_accept_stall", {31'd0, MemStall}, 32'd1);
    for (int i = 0; i < LAT; i++) begin
      step();
      chk($sformatf("t2 b_busy%0d_stall", i), {31'd0, MemStall}, 32'd1);
    end
    step();
    chk("t2 b_done_stall", {31'd0, MemStall}, 32'd0);
    chk("t2 b_done_rdata", ReadData, 32'h24242424);
    MemRead = 1'b0;
    step();
    chk("t2 idle_stall", {31'd0, MemStall}, 32'd0);

    // 3: misaligned write rejected, memory untouched
    do_req(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1, "t3_misal");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t3_rd10");

    // 4: read+write together rejected
    do_req(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 32'hDEADBEEF, 1'b0, "t4_wr30");
    do_req(1'b1, 1'b1, 32'h30, 32'h77777777, 32'h0, 1'b1, "t4_both");
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, "t4_rd30");

    // 5: reset in second busy cycle aborts the store
    do_req(1'b0, 1'b1, 32'h40, 32'h11112222, 32'h0BADF00D, 1'b0, "t5_wr_old");
    MemWrite  = 1'b1;
    Address   = 32'h40;
    WriteData = 32'h12345678;
    step();
    step();
    rst      = 1'b1;
    MemWrite = 1'b0;
    step();
    rst = 1'b0;
    chk("t5 post_reset_stall", {31'd0, MemStall}, 32'd0);
    chk("t5 post_reset_rdata", ReadData, 32'd0);
    chk("t5 post_reset_err", {31'd0, Err}, 32'd0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'h11112222, 1'b0, "t5_rd40");

    // 6: aliasing at DEPTH*4
    do_req(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h11112222, 1'b0, "t6_wr1000");
    do_req(1'b1, 1'b0, 32'h0000, 32'h0, 32'hA5A5A5A5, 1'b0, "t6_rd0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
